// File: rtl/md_pkg.sv
// Shared encodings and defaults for the HI/LO multiply/divide scheduler.
package md_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdState_e;

    // Ops that occupy the unit for a fixed latency and write both HI and LO.
    function automatic logic isArithOp(input logic [2:0] o);
        return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic isDivOp(input logic [2:0] o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO result generator for MULT/MULTU/DIV/DIVU.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_n,
    output logic [31:0] lo_n,
    output logic        div_by_zero
);

    logic signed [63:0] sProd;
    logic [63:0]        uProd;
    logic               divOvf;
    logic [31:0]        sDivisor;
    logic [31:0]        uDivisor;
    logic signed [31:0] sQuo;
    logic signed [31:0] sRem;
    logic [31:0]        uQuo;
    logic [31:0]        uRem;

    assign sProd = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign uProd = {32'b0, a} * {32'b0, b};

    // Divisor is forced to 1 for b==0 (result discarded) and for the
    // 0x80000000 / -1 overflow, where dividing by 1 yields the wrapped answer.
    assign divOvf   = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign sDivisor = ((b == 32'd0) || divOvf) ? 32'd1 : b;
    assign uDivisor = (b == 32'd0) ? 32'd1 : b;

    assign sQuo = $signed(a) / $signed(sDivisor);
    assign sRem = $signed(a) % $signed(sDivisor);
    assign uQuo = a / uDivisor;
    assign uRem = a % uDivisor;

    assign div_by_zero = isDivOp(op) && (b == 32'd0);

    always_comb begin
        hi_n = 32'd0;
        lo_n = 32'd0;
        case (op)
            OP_MULT:  {hi_n, lo_n} = sProd;
            OP_MULTU: {hi_n, lo_n} = uProd;
            OP_DIV: begin
                hi_n = sRem;
                lo_n = sQuo;
            end
            OP_DIVU: begin
                hi_n = uRem;
                lo_n = uQuo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// HI/LO owner and fixed-latency multiply/divide scheduler with D-stage stall request.
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    mdState_e      state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic [2:0]    opQ, opNext;
    logic [31:0]   aQ, aNext;
    logic [31:0]   bQ, bNext;
    logic [31:0]   hiNext, loNext;
    logic [31:0]   hiRes, loRes;
    logic          divByZero;

    md_arith uArith (
        .op          (opQ),
        .a           (aQ),
        .b           (bQ),
        .hi_n        (hiRes),
        .lo_n        (loRes),
        .div_by_zero (divByZero)
    );

    assign busy      = (state == ST_BUSY);
    // Includes the start cycle so a back-to-back md instruction in D stalls at once.
    assign stall_req = md_use_d & (busy | (start & isArithOp(op)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            opQ   <= 3'd0;
            aQ    <= 32'd0;
            bQ    <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            opQ   <= opNext;
            aQ    <= aNext;
            bQ    <= bNext;
            hi    <= hiNext;
            lo    <= loNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        opNext    = opQ;
        aNext     = aQ;
        bNext     = bQ;
        hiNext    = hi;
        loNext    = lo;
        case (state)
            ST_IDLE: begin
                if (start && !flush) begin
                    if (isArithOp(op)) begin
                        stateNext = ST_BUSY;
                        opNext    = op;
                        aNext     = a;
                        bNext     = b;
                        cntNext   = isDivOp(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    end else if (op == OP_MTHI) begin
                        hiNext = a;
                    end else if (op == OP_MTLO) begin
                        loNext = a;
                    end
                end
            end
            ST_BUSY: begin
                // Flush beats the commit edge; start is ignored while busy.
                if (flush) begin
                    stateNext = ST_IDLE;
                    cntNext   = '0;
                end else if (cnt == CW'(1)) begin
                    stateNext = ST_IDLE;
                    cntNext   = '0;
                    if (!divByZero) begin
                        hiNext = hiRes;
                        loNext = loRes;
                    end
                end else begin
                    cntNext = cnt - CW'(1);
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_md_sched.sv
// Randomized self-checking bench for md_sched against a behavioural HI/LO model.
module tb_md_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        md_use_d;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] refHi, refLo;

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .md_use_d  (md_use_d),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of one completed op on HI/LO.
    task automatic refOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        longint unsigned ux, uy, p;
        sx = $signed(x);
        sy = $signed(y);
        ux = x;
        uy = y;
        case (o)
            3'd0: begin
                q = sx * sy;
                refHi = q[63:32];
                refLo = q[31:0];
            end
            3'd1: begin
                p = ux * uy;
                refHi = p[63:32];
                refLo = p[31:0];
            end
            3'd2: if (y != 0) begin
                q = sx / sy;
                r = sx % sy;
                refLo = q[31:0];
                refHi = r[31:0];
            end
            3'd3: if (y != 0) begin
                refLo = x / y;
                refHi = x % y;
            end
            3'd4: refHi = x;
            3'd5: refLo = x;
            default: ;
        endcase
    endtask

    function automatic int refLat(input logic [2:0] o);
        if (o == 3'd0 || o == 3'd1) return 5;
        if (o == 3'd2 || o == 3'd3) return 10;
        return 0;
    endfunction

    // Issues one op and counts busy cycles until the unit is idle again (bounded).
    task automatic runOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int n);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0; md_use_d = 1'b1;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
        total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo); end
        reset = 1'b0;
        md_use_d = 1'b0;
        step();
        refHi = 0; refLo = 0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_mult;
        int n;
        runOp(3'd0, 32'hFFFF_FFFD, 32'd5, n);
        refOp(3'd0, 32'hFFFF_FFFD, 32'd5);
        total++; if (n !== 5) begin bad++; $display("FAIL mult_lat got=%0d exp=5", n); end
        total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin bad++; $display("FAIL mult_res got=%h/%h exp=ffffffff/fffffff1", hi, lo); end
        total++; if (hi !== refHi || lo !== refLo) begin bad++; $display("FAIL mult_model got=%h/%h exp=%h/%h", hi, lo, refHi, refLo); end
    endtask

    task automatic test_div;
        int n;
        runOp(3'd2, 32'hFFFF_FFF9, 32'd2, n);
        refOp(3'd2, 32'hFFFF_FFF9, 32'd2);
        total++; if (n !== 10) begin bad++; $display("FAIL div_lat got=%0d exp=10", n); end
        total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_res got=%h/%h exp=ffffffff/fffffffd", hi, lo); end
        runOp(3'd3, 32'd7, 32'd2, n);
        refOp(3'd3, 32'd7, 32'd2);
        total++; if (hi !== 32'd1 || lo !== 32'd3) begin bad++; $display("FAIL divu_res got=%h/%h exp=1/3", hi, lo); end
        runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
        refOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        total++; if (hi !== 32'd0 || lo !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf got=%h/%h exp=0/80000000", hi, lo); end
    endtask

    task automatic test_mthi_divzero;
        int n;
        runOp(3'd4, 32'h1234_5678, 32'd0, n);
        refOp(3'd4, 32'h1234_5678, 32'd0);
        total++; if (n !== 0 || hi !== 32'h1234_5678) begin bad++; $display("FAIL mthi got n=%0d hi=%h exp n=0 hi=12345678", n, hi); end
        runOp(3'd3, 32'hDEAD_BEEF, 32'd0, n);
        refOp(3'd3, 32'hDEAD_BEEF, 32'd0);
        total++; if (n !== 10) begin bad++; $display("FAIL divz_lat got=%0d exp=10", n); end
        total++; if (hi !== 32'h1234_5678 || lo !== refLo) begin bad++; $display("FAIL divz_hold got=%h/%h exp=12345678/%h", hi, lo, refLo); end
    endtask

    task automatic test_back_to_back;
        int n;
        start = 1'b1; op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        step();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == 2) begin
                start = 1'b1; op = 3'd2; a = $urandom; b = 32'd3;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        refOp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        total++; if (n !== 5) begin bad++; $display("FAIL b2b_lat got=%0d exp=5", n); end
        total++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin bad++; $display("FAIL b2b_res got=%h/%h exp=fffffffe/00000001", hi, lo); end
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_ignored got busy=%b exp=0", busy); end
    endtask

    task automatic test_stall;
        int n, good;
        md_use_d = 1'b1;
        start = 1'b1; op = 3'd4; a = refHi;
        #1;
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL stall_mthi got=%b exp=0", stall_req); end
        op = 3'd0; a = $urandom; b = $urandom;
        #1;
        total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL stall_start got=%b exp=1", stall_req); end
        refOp(3'd0, a, b);
        step();
        start = 1'b0;
        n = 0; good = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (stall_req === 1'b1) good++;
            step();
        end
        total++; if (n !== 5 || good !== 5) begin bad++; $display("FAIL stall_busy got n=%0d stalled=%0d exp 5/5", n, good); end
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL stall_drop got=%b exp=0", stall_req); end
        md_use_d = 1'b0;
    endtask

    task automatic test_reset_mid;
        start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
        step();
        start = 1'b0;
        step(); step();
        #1 reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL reset_mid got busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo); end
        reset = 1'b0;
        refHi = 0; refLo = 0;
        step();
        total++; if (busy !== 1'b0 || hi !== 32'd0) begin bad++; $display("FAIL reset_mid_after got busy=%b hi=%h exp 0/0", busy, hi); end
    endtask

    task automatic test_flush;
        int n;
        runOp(3'd4, 32'hAAAA_0001, 32'd0, n); refOp(3'd4, 32'hAAAA_0001, 32'd0);
        runOp(3'd5, 32'h5555_0002, 32'd0, n); refOp(3'd5, 32'h5555_0002, 32'd0);
        start = 1'b1; op = 3'd0; a = 32'd100; b = 32'd200;
        step();
        start = 1'b0;
        step(); step();
        flush = 1'b1;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_pre got busy=%b exp=1", busy); end
        step();
        flush = 1'b0;
        total++; if (busy !== 1'b0 || hi !== refHi || lo !== refLo) begin bad++; $display("FAIL flush_mid got busy=%b %h/%h exp 0 %h/%h", busy, hi, lo, refHi, refLo); end
        // flush on the commit edge
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
        step();
        start = 1'b0;
        step(); step(); step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        total++; if (busy !== 1'b0 || hi !== refHi || lo !== refLo) begin bad++; $display("FAIL flush_commit got busy=%b %h/%h exp 0 %h/%h", busy, hi, lo, refHi, refLo); end
        // flush with start in idle
        flush = 1'b1; start = 1'b1; op = 3'd4; a = 32'hFFFF_0000;
        step();
        op = 3'd2; b = 32'd1;
        step();
        flush = 1'b0; start = 1'b0;
        step();
        total++; if (busy !== 1'b0 || hi !== refHi) begin bad++; $display("FAIL flush_start got busy=%b hi=%h exp 0 %h", busy, hi, refHi); end
    endtask

    task automatic test_random;
        int n;
        logic [2:0]  o;
        logic [31:0] x, y;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: x = 32'h8000_0000;
                3: y = 32'($urandom_range(1, 9));
                default: ;
            endcase
            runOp(o, x, y, n);
            refOp(o, x, y);
            total++;
            if (n !== refLat(o) || hi !== refHi || lo !== refLo) begin
                bad++;
                $display("FAIL rand%0d op=%0d a=%h b=%h got n=%0d %h/%h exp n=%0d %h/%h",
                         i, o, x, y, n, hi, lo, refLat(o), refHi, refLo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_divzero();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
